// File: rtl/display_mode_ctrl.sv
// Display mode sequencer: cycles CLOCK/TIMER/STOPWATCH views on mode edges,
// falls back to CLOCK on idle timeout and raises a blinking ALARM view on timer expiry.
module display_mode_ctrl #(
  parameter int unsigned IDLE_TICKS  = 3000,
  parameter int unsigned ALARM_TICKS = 1000,
  parameter int unsigned BLINK_HALF  = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       mode_btn,
  input  logic       ack_btn,
  input  logic       tmr_done,
  input  logic       sw_running,
  output logic [1:0] sel,
  output logic       blank,
  output logic       alarm
);

  localparam int unsigned IW = $clog2(IDLE_TICKS + 1);
  localparam int unsigned AW = $clog2(ALARM_TICKS + 1);
  localparam int unsigned BW = $clog2(BLINK_HALF + 1);

  typedef enum logic [1:0] {
    S_CLOCK,
    S_TIMER,
    S_STOPWATCH,
    S_ALARM
  } state_e;

  state_e        state_q, state_d;
  logic          mode_q, ack_q;
  logic [IW-1:0] idle_q, idle_d;
  logic [AW-1:0] acnt_q, acnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          blank_q, blank_d;
  logic [1:0]    sel_q, sel_d;
  logic          alarm_q, alarm_d;
  logic          mode_edge, ack_edge;

  assign mode_edge = mode_btn & ~mode_q;
  assign ack_edge  = ack_btn & ~ack_q;

  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    acnt_d  = '0;
    bcnt_d  = '0;
    blank_d = 1'b0;
    if (tmr_done) begin
      state_d = S_ALARM;
      idle_d  = '0;
    end else if (state_q == S_ALARM) begin
      acnt_d  = acnt_q;
      bcnt_d  = bcnt_q;
      blank_d = blank_q;
      if (mode_edge || ack_edge) begin
        state_d = S_TIMER;
        acnt_d  = '0;
        bcnt_d  = '0;
        blank_d = 1'b0;
      end else if (tick) begin
        if (acnt_q == AW'(ALARM_TICKS - 1)) begin
          state_d = S_TIMER;
          acnt_d  = '0;
          bcnt_d  = '0;
          blank_d = 1'b0;
        end else begin
          acnt_d = acnt_q + AW'(1);
          if (bcnt_q == BW'(BLINK_HALF - 1)) begin
            bcnt_d  = '0;
            blank_d = ~blank_q;
          end else begin
            bcnt_d = bcnt_q + BW'(1);
          end
        end
      end
    end else if (mode_edge) begin
      idle_d = '0;
      case (state_q)
        S_CLOCK:     state_d = S_TIMER;
        S_TIMER:     state_d = S_STOPWATCH;
        default:     state_d = S_CLOCK;
      endcase
    end else if (ack_edge) begin
      idle_d = '0;
    end else if (state_q == S_CLOCK || (state_q == S_STOPWATCH && sw_running)) begin
      idle_d = '0;
    end else if (tick) begin
      // Timeout fires on the tick that would make the count reach IDLE_TICKS.
      if (idle_q == IW'(IDLE_TICKS - 1)) begin
        state_d = S_CLOCK;
        idle_d  = '0;
      end else begin
        idle_d = idle_q + IW'(1);
      end
    end

    case (state_d)
      S_CLOCK:     sel_d = 2'b01;
      S_STOPWATCH: sel_d = 2'b11;
      default:     sel_d = 2'b10;
    endcase
    alarm_d = (state_d == S_ALARM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLOCK;
      mode_q  <= 1'b1;
      ack_q   <= 1'b1;
      idle_q  <= '0;
      acnt_q  <= '0;
      bcnt_q  <= '0;
      blank_q <= 1'b0;
      sel_q   <= 2'b01;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_btn;
      ack_q   <= ack_btn;
      idle_q  <= idle_d;
      acnt_q  <= acnt_d;
      bcnt_q  <= bcnt_d;
      blank_q <= blank_d;
      sel_q   <= sel_d;
      alarm_q <= alarm_d;
    end
  end

  assign sel   = sel_q;
  assign blank = blank_q;
  assign alarm = alarm_q;

endmodule

// File: tb/tb_display_mode_ctrl.sv
// Scoreboard bench for display_mode_ctrl: each driven cycle queues the expected
// {sel, blank, alarm} seen after the next clock edge; a negedge monitor compares.
module tb_display_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst, tick, mode_btn, ack_btn, tmr_done, sw_running;
  logic [1:0] sel;
  logic       blank, alarm;

  typedef struct {
    int unsigned due;
    logic [3:0]  exp;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int unsigned pe_cnt  = 0;
  int unsigned n_chk   = 0;
  int unsigned n_pass  = 0;

  localparam logic [3:0] V_CLK  = 4'b01_0_0;
  localparam logic [3:0] V_TMR  = 4'b10_0_0;
  localparam logic [3:0] V_SW   = 4'b11_0_0;
  localparam logic [3:0] V_AL0  = 4'b10_0_1;
  localparam logic [3:0] V_AL1  = 4'b10_1_1;

  display_mode_ctrl #(
    .IDLE_TICKS (3000),
    .ALARM_TICKS(1000),
    .BLINK_HALF (50)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .mode_btn  (mode_btn),
    .ack_btn   (ack_btn),
    .tmr_done  (tmr_done),
    .sw_running(sw_running),
    .sel       (sel),
    .blank     (blank),
    .alarm     (alarm)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pe_cnt++;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got sel/blank/alarm=%b_%b_%b, expected %b_%b_%b at t=%0t",
                  tag, obs[3:2], obs[1], obs[0], exp[3:2], exp[1], exp[0], $time);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= pe_cnt) begin
      exp_t e;
      e = sb.pop_front();
      check(e.tag, {sel, blank, alarm}, e.exp);
    end
  end

  // Drive one cycle of inputs and queue what the outputs must be after the next edge.
  task automatic drive(input logic r, t, m, a, d, s, input logic [3:0] exp, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; tick = t; mode_btn = m; ack_btn = a; tmr_done = d; sw_running = s;
    e.due = pe_cnt + 1;
    e.exp = exp;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic ticks(input int unsigned n, input logic s, input logic [3:0] exp, input string tag);
    for (int unsigned i = 0; i < n; i++) begin
      drive(0, 1, 0, 0, 0, s, exp, tag);
      drive(0, 0, 0, 0, 0, s, exp, tag);
    end
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; mode_btn = 1'b1; ack_btn = 1'b0; tmr_done = 1'b0; sw_running = 1'b0;

    // 1: reset, mode held high through reset gives no edge
    drive(1, 0, 1, 0, 0, 0, V_CLK, "rst0");
    drive(1, 0, 1, 0, 0, 0, V_CLK, "rst1");
    drive(0, 0, 1, 0, 0, 0, V_CLK, "held_mode");
    drive(0, 0, 1, 0, 0, 0, V_CLK, "held_mode2");
    drive(0, 0, 0, 0, 0, 0, V_CLK, "release");

    // 2: mode cycle
    drive(0, 0, 1, 0, 0, 0, V_TMR, "mode_to_tmr");
    drive(0, 0, 0, 0, 0, 0, V_TMR, "mode_rel1");
    drive(0, 0, 1, 0, 0, 0, V_SW,  "mode_to_sw");
    drive(0, 0, 0, 0, 0, 0, V_SW,  "mode_rel2");
    drive(0, 0, 1, 0, 0, 0, V_CLK, "mode_to_clk");
    drive(0, 0, 0, 0, 0, 0, V_CLK, "mode_rel3");
    ticks(5, 0, V_CLK, "clk_no_timeout");

    // 3: TIMER idle timeout, ack edge together with tick 2000 restarts the count
    drive(0, 0, 1, 0, 0, 0, V_TMR, "enter_tmr");
    drive(0, 0, 0, 0, 0, 0, V_TMR, "enter_tmr_rel");
    ticks(1999, 0, V_TMR, "tmr_pre_ack");
    drive(0, 1, 0, 1, 0, 0, V_TMR, "ack_tick");
    drive(0, 0, 0, 0, 0, 0, V_TMR, "ack_rel");
    ticks(2999, 0, V_TMR, "tmr_2999");
    ticks(1, 0, V_CLK, "tmr_timeout");

    // 4: STOPWATCH held by sw_running, then times out
    drive(0, 0, 1, 0, 0, 1, V_TMR, "sw_step1");
    drive(0, 0, 0, 0, 0, 1, V_TMR, "sw_rel1");
    drive(0, 0, 1, 0, 0, 1, V_SW,  "sw_step2");
    drive(0, 0, 0, 0, 0, 1, V_SW,  "sw_rel2");
    ticks(5000, 1, V_SW, "sw_running");
    ticks(2999, 0, V_SW, "sw_2999");
    ticks(1, 0, V_CLK, "sw_timeout");

    // 5: tmr_done beats a simultaneous mode edge; blink; ack exits
    drive(0, 0, 1, 0, 1, 0, V_AL0, "tmr_done_vs_mode");
    drive(0, 0, 0, 0, 0, 0, V_AL0, "alarm_rel");
    ticks(49, 0, V_AL0, "blink_ph0");
    ticks(1,  0, V_AL1, "blink_50");
    ticks(49, 0, V_AL1, "blink_ph1");
    ticks(1,  0, V_AL0, "blink_100");
    drive(0, 0, 0, 1, 0, 0, V_TMR, "ack_exit");
    drive(0, 0, 0, 0, 0, 0, V_TMR, "ack_exit_rel");

    // 6: ALARM auto-clear after 1000 ticks, blank toggling every 50
    drive(0, 0, 0, 0, 1, 0, V_AL0, "alarm2_enter");
    for (int unsigned j = 0; j < 20; j++) begin
      ticks(49, 0, j[0] ? V_AL1 : V_AL0, "alarm2_phase");
      if (j == 19) ticks(1, 0, V_TMR, "alarm_autoclear");
      else         ticks(1, 0, j[0] ? V_AL0 : V_AL1, "alarm2_toggle");
    end

    // tmr_done inside ALARM restarts counters; then reset mid-alarm
    drive(0, 0, 0, 0, 1, 0, V_AL0, "alarm3_enter");
    ticks(30, 0, V_AL0, "alarm3_pre");
    drive(0, 0, 0, 0, 1, 0, V_AL0, "alarm3_retrig");
    ticks(49, 0, V_AL0, "alarm3_ph0");
    ticks(1,  0, V_AL1, "alarm3_50");
    drive(1, 0, 0, 0, 0, 0, V_CLK, "rst_in_alarm");
    drive(0, 0, 0, 0, 0, 0, V_CLK, "after_rst");
    ticks(3, 0, V_CLK, "after_rst_idle");

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
